// File: rtl/ex_operand_stage_pkg.sv
// Shared constants and types for the EX operand stage: ALU codes, ALUOp encodings,
// R-type opcodes, the XZR index and the ID/EX control payload.
package ex_operand_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned OPCODE_W  = 11;
    localparam int unsigned ALU_SEL_W = 4;
    localparam int unsigned ALU_OP_W  = 2;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_AND    = 4'b0000,
        ALU_ORR    = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_SUB    = 4'b0110,
        ALU_PASS_B = 4'b0111,
        ALU_NOR    = 4'b1100
    } alu_sel_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_PASS_B = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } alu_op_e;

    localparam logic [OPCODE_W-1:0] OPC_ADD = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] OPC_SUB = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] OPC_AND = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OPC_ORR = 11'b10101010000;

    localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

    // Control fields carried through the ID/EX register (data words kept separate: width is a parameter)
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [ALU_OP_W-1:0]  alu_op;
        logic [OPCODE_W-1:0]  opcode;
        logic                 alu_src;
        logic                 reg_write;
    } id_ctrl_t;

    // A later-stage writer supplies the operand unless the source is XZR
    function automatic logic fwd_hit(input logic we,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs);
        return we && (rd == rs) && (rs != XZR_IDX);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX operand outputs.
interface ex_operand_stage_if #(
    parameter int unsigned n = 63
);
    logic       in_valid;
    logic       stall;
    logic       flush;
    logic [n:0] id_rs1_data;
    logic [n:0] id_rs2_data;
    logic [n:0] id_imm;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic [1:0] id_alu_op;
    logic [10:0] id_opcode;
    logic       id_alu_src;
    logic       id_reg_write;

    logic       exmem_reg_write;
    logic       memwb_reg_write;
    logic [4:0] exmem_rd;
    logic [4:0] memwb_rd;
    logic [n:0] exmem_result;
    logic [n:0] memwb_result;

    logic [n:0] data1;
    logic [n:0] data2;
    logic [3:0] ALU_Select;
    logic [n:0] store_data;
    logic       ex_valid;
    logic       ex_reg_write;
    logic       ex_illegal;
    logic [4:0] ex_rd;

    modport master (
        output in_valid, stall, flush,
        output id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
        output id_alu_op, id_opcode, id_alu_src, id_reg_write,
        output exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
        output exmem_result, memwb_result,
        input  data1, data2, ALU_Select, store_data,
        input  ex_valid, ex_reg_write, ex_illegal, ex_rd
    );

    modport slave (
        input  in_valid, stall, flush,
        input  id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
        input  id_alu_op, id_opcode, id_alu_src, id_reg_write,
        input  exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
        input  exmem_result, memwb_result,
        output data1, data2, ALU_Select, store_data,
        output ex_valid, ex_reg_write, ex_illegal, ex_rd
    );

endinterface

// File: rtl/ex_operand_stage_alu_control.sv
// ALU control decode: ALUOp plus instruction[31:21] to a 4-bit ALU operation code.
module ex_operand_stage_alu_control
    import ex_operand_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  alu_op,
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 illegal
);

    // Unknown combinations fall back to ADD and raise illegal
    always_comb begin
        alu_select = ALU_ADD;
        illegal    = 1'b0;
        case (alu_op)
            ALUOP_ADD:    alu_select = ALU_ADD;
            ALUOP_PASS_B: alu_select = ALU_PASS_B;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: alu_select = ALU_ADD;
                    OPC_SUB: alu_select = ALU_SUB;
                    OPC_AND: alu_select = ALU_AND;
                    OPC_ORR: alu_select = ALU_ORR;
                    default: illegal    = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and ALU control decode.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned n = 63
) (
    input  logic             clk,
    input  logic             reset,
    ex_operand_stage_if.slave bus
);

    logic       valid_q;
    logic [n:0] rs1_data_q;
    logic [n:0] rs2_data_q;
    logic [n:0] imm_q;
    id_ctrl_t   ctrl_q;
    id_ctrl_t   ctrl_d;

    logic [n:0]           fwd_a;
    logic [n:0]           fwd_b;
    logic [ALU_SEL_W-1:0] alu_sel_c;
    logic                 illegal_c;

    assign ctrl_d = '{
        rs1:       bus.id_rs1,
        rs2:       bus.id_rs2,
        rd:        bus.id_rd,
        alu_op:    bus.id_alu_op,
        opcode:    bus.id_opcode,
        alu_src:   bus.id_alu_src,
        reg_write: bus.id_reg_write
    };

    // Pipeline register: reset > flush (squash valid only) > stall (hold) > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            ctrl_q     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q    <= bus.in_valid;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            ctrl_q     <= ctrl_d;
        end
    end

    // EX/MEM is the younger result, so it is checked first
    always_comb begin
        fwd_a = rs1_data_q;
        fwd_b = rs2_data_q;
        if (fwd_hit(bus.exmem_reg_write, bus.exmem_rd, ctrl_q.rs1)) begin
            fwd_a = bus.exmem_result;
        end else if (fwd_hit(bus.memwb_reg_write, bus.memwb_rd, ctrl_q.rs1)) begin
            fwd_a = bus.memwb_result;
        end
        if (fwd_hit(bus.exmem_reg_write, bus.exmem_rd, ctrl_q.rs2)) begin
            fwd_b = bus.exmem_result;
        end else if (fwd_hit(bus.memwb_reg_write, bus.memwb_rd, ctrl_q.rs2)) begin
            fwd_b = bus.memwb_result;
        end
    end

    ex_operand_stage_alu_control alu_control (
        .alu_op     (ctrl_q.alu_op),
        .opcode     (ctrl_q.opcode),
        .alu_select (alu_sel_c),
        .illegal    (illegal_c)
    );

    // A bubble presents quiet operands so downstream logic sees a harmless ADD of zeros
    assign bus.data1        = valid_q ? fwd_a : '0;
    assign bus.store_data   = valid_q ? fwd_b : '0;
    assign bus.data2        = !valid_q ? '0 : (ctrl_q.alu_src ? imm_q : fwd_b);
    assign bus.ALU_Select   = valid_q ? alu_sel_c : ALU_SEL_W'(ALU_ADD);
    assign bus.ex_valid     = valid_q;
    assign bus.ex_reg_write = valid_q & ctrl_q.reg_write;
    assign bus.ex_illegal   = valid_q & illegal_c;
    assign bus.ex_rd        = ctrl_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: driver pushes expectations, negedge monitor pops and compares.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    localparam int unsigned N = 63;
    localparam int unsigned W = N + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.n(N)) bus ();

    ex_operand_stage #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [N:0] d1;
        logic [N:0] d2;
        logic [N:0] sd;
        logic [3:0] alu;
        logic       v;
        logic       rw;
        logic       ill;
        logic [4:0] rd;
        bit         rd_chk;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input string fld, input logic [N:0] act, input logic [N:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare mid-cycle, when registered state and forwarding inputs are stable
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, "data1",        bus.data1,              e.d1);
                chk(e.name, "data2",        bus.data2,              e.d2);
                chk(e.name, "store_data",   bus.store_data,         e.sd);
                chk(e.name, "ALU_Select",   W'(bus.ALU_Select),     W'(e.alu));
                chk(e.name, "ex_valid",     W'(bus.ex_valid),       W'(e.v));
                chk(e.name, "ex_reg_write", W'(bus.ex_reg_write),   W'(e.rw));
                chk(e.name, "ex_illegal",   W'(bus.ex_illegal),     W'(e.ill));
                if (e.rd_chk) chk(e.name, "ex_rd", W'(bus.ex_rd), W'(e.rd));
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic [N:0] d1, input logic [N:0] d2,
                                input logic [N:0] sd, input logic [3:0] alu, input logic v,
                                input logic rw, input logic ill, input logic [4:0] rd, input bit rd_chk);
        exp_t e;
        e.name = nm; e.d1 = d1; e.d2 = d2; e.sd = sd; e.alu = alu;
        e.v = v; e.rw = rw; e.ill = ill; e.rd = rd; e.rd_chk = rd_chk;
        return e;
    endfunction

    function automatic exp_t idle(input string nm, input logic [4:0] rd, input bit rd_chk);
        return mk(nm, '0, '0, '0, 4'b0010, 1'b0, 1'b0, 1'b0, rd, rd_chk);
    endfunction

    task automatic set_id(input logic v, input logic [N:0] a, input logic [N:0] b, input logic [N:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [1:0] op, input logic [10:0] opc, input logic src, input logic rw);
        bus.in_valid = v;       bus.id_rs1_data = a;   bus.id_rs2_data = b;
        bus.id_imm = imm;       bus.id_rs1 = rs1;      bus.id_rs2 = rs2;
        bus.id_rd = rd;         bus.id_alu_op = op;    bus.id_opcode = opc;
        bus.id_alu_src = src;   bus.id_reg_write = rw;
    endtask

    task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [N:0] eres,
                           input logic mwe, input logic [4:0] mrd, input logic [N:0] mres);
        bus.exmem_reg_write = ewe; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mwe; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    // One clock: inputs set before the edge, expectation checked at the following negedge
    task automatic tick(input bit do_chk, input exp_t e);
        @(posedge clk);
        #1;
        if (do_chk) sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    localparam logic [N:0] NEG4 = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        exp_t held;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_fwd(0, 0, '0, 0, 0, '0);
        set_id(1, 'h99, 'h98, 'h97, 1, 2, 5, 2'b10, OPC_ADD, 0, 1);
        tick(1, idle("reset", 0, 1));
        tick(1, idle("reset2", 0, 1));

        reset = 1'b0;
        set_id(1, 5, 7, 0, 1, 2, 4, 2'b10, OPC_ADD, 0, 1);
        tick(1, mk("add", 5, 7, 7, 4'b0010, 1, 1, 0, 4, 1));

        set_id(1, 'h11, 9, 0, 3, 5, 6, 2'b10, OPC_SUB, 0, 1);
        set_fwd(1, 3, 'hAA, 1, 3, 'hBB);
        tick(1, mk("dbl_ex", 'hAA, 9, 9, 4'b0110, 1, 1, 0, 6, 1));
        set_fwd(0, 3, 'hAA, 1, 3, 'hBB);
        tick(1, mk("dbl_wb", 'hBB, 9, 9, 4'b0110, 1, 1, 0, 6, 1));

        set_id(1, 'h11, 9, 0, 3, 5, 6, 2'b10, OPC_AND, 0, 0);
        set_fwd(1, 7, 'h77, 1, 5, 'h123);
        tick(1, mk("fwd_b_wb", 'h11, 'h123, 'h123, 4'b0000, 1, 0, 0, 6, 1));
        set_fwd(1, 5, 'h321, 1, 5, 'h123);
        tick(1, mk("fwd_b_ex", 'h11, 'h321, 'h321, 4'b0000, 1, 0, 0, 6, 1));

        set_id(1, 2, 0, 0, 1, 31, 7, 2'b10, OPC_ORR, 0, 1);
        set_fwd(1, 31, 'h55, 1, 31, 'h66);
        tick(1, mk("xzr", 2, 0, 0, 4'b0001, 1, 1, 0, 7, 1));

        set_fwd(0, 0, '0, 0, 0, '0);
        set_id(1, 5, 7, NEG4, 1, 2, 8, 2'b00, 11'd0, 1, 1);
        tick(1, mk("imm", 5, NEG4, 7, 4'b0010, 1, 1, 0, 8, 1));
        set_id(1, 5, 7, NEG4, 1, 2, 8, 2'b10, 11'd0, 0, 1);
        tick(1, mk("illegal", 5, 7, 7, 4'b0010, 1, 1, 1, 8, 1));
        set_id(1, 5, 7, NEG4, 1, 2, 8, 2'b01, 11'd0, 1, 1);
        tick(1, mk("pass_b", 5, NEG4, 7, 4'b0111, 1, 1, 0, 8, 1));
        set_id(1, 5, 7, NEG4, 1, 2, 8, 2'b11, OPC_ADD, 0, 1);
        tick(1, mk("op11", 5, 7, 7, 4'b0010, 1, 1, 1, 8, 1));

        set_id(0, 5, 7, 0, 1, 2, 10, 2'b10, OPC_ADD, 0, 1);
        set_fwd(1, 1, 'hAB, 0, 0, '0);
        tick(1, idle("bubble", 10, 1));

        set_fwd(0, 0, '0, 0, 0, '0);
        set_id(1, 'h100, 'h200, 0, 1, 2, 9, 2'b10, OPC_ADD, 0, 1);
        held = mk("pre_stall", 'h100, 'h200, 'h200, 4'b0010, 1, 1, 0, 9, 1);
        tick(1, held);
        bus.stall = 1'b1;
        set_id(0, 'hDEAD, 'hBEEF, 5, 3, 4, 11, 2'b10, OPC_SUB, 1, 0);
        held.name = "stall1";
        tick(1, held);
        set_id(1, 'hCAFE, 'hF00D, 6, 6, 7, 12, 2'b01, OPC_ORR, 1, 0);
        held.name = "stall2";
        tick(1, held);
        bus.flush = 1'b1;
        tick(1, idle("flush_stall", 0, 0));
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_id(1, 'h100, 'h200, 0, 1, 2, 9, 2'b10, OPC_ADD, 0, 1);
        held.name = "resume";
        tick(1, held);
        bus.flush = 1'b1;
        tick(1, idle("flush_only", 0, 0));
        bus.flush = 1'b0;

        set_id(1, 'h30, 'h10, 0, 1, 2, 12, 2'b10, OPC_SUB, 0, 1);
        held = mk("sub", 'h30, 'h10, 'h10, 4'b0110, 1, 1, 0, 12, 1);
        tick(1, held);
        bus.stall = 1'b1;
        set_id(1, 'h1, 'h2, 0, 3, 4, 13, 2'b10, OPC_AND, 0, 1);
        held.name = "sub_hold";
        tick(1, held);
        reset = 1'b1;
        tick(1, idle("reset_stall", 0, 1));
        reset = 1'b0;
        bus.stall = 1'b0;
        set_id(1, 5, 7, 0, 1, 2, 4, 2'b10, OPC_ADD, 0, 1);
        tick(1, mk("post_reset", 5, 7, 7, 4'b0010, 1, 1, 0, 4, 1));

        tick(0, held);
        tick(0, held);
        chk("drain", "pending", W'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb.size());
        $fatal(1, "timeout");
    end

endmodule
